sub_serial: RTL and testbench

Bit-serial 2's-complement subtractor, the inverse companion of the serial adder in the same datapath. Latches two parallel operands on a start request, computes `a - b` one bit per cycle LSB-first through a single full-subtractor cell with a borrow register, and presents the parallel difference, final borrow and a one-cycle completion pulse. Used where area matters more than latency: one subtract per `WIDTH+2` cycles.

---
 rtl/sub_serial.sv | 111 +++++++++++
 tb/tb_sub_serial.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sub_serial.sv
// rtl/sub_serial.sv - bit-serial LSB-first 2's-complement subtractor, one result per WIDTH+2 cycles
// Optional signed-overflow output enabled by defining SUB_SERIAL_OVF_EN.
module sub_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             borrow,
    output logic             done,
`ifdef SUB_SERIAL_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUB  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             brw;
    logic [CW-1:0]    count;
    logic             d;
    logic             brw_nxt;
    logic             last_bit;

    // Full-subtractor cell on the current LSB pair.
    assign d        = a_reg[0] ^ b_reg[0] ^ brw;
    assign brw_nxt  = (~a_reg[0] & b_reg[0]) | (~a_reg[0] & brw) | (b_reg[0] & brw);
    assign last_bit = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:  state_nxt = en ? S_SUB : S_IDLE;
            S_SUB:   state_nxt = last_bit ? S_DONE : S_SUB;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign done = (state == S_DONE);
    assign busy = (state != S_IDLE);

`ifdef SUB_SERIAL_OVF_EN
    logic sa;
    logic sb;

    always_ff @(posedge clk) begin
        if (rst) begin
            sa  <= 1'b0;
            sb  <= 1'b0;
            ovf <= 1'b0;
        end else if (state == S_IDLE && en) begin
            sa  <= a[WIDTH-1];
            sb  <= b[WIDTH-1];
            ovf <= 1'b0;
        end else if (state == S_SUB && last_bit) begin
            ovf <= (sa ^ sb) & (d ^ sa);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg  <= '0;
            b_reg  <= '0;
            brw    <= 1'b0;
            count  <= '0;
            out    <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en) begin
                        a_reg  <= a;
                        b_reg  <= b;
                        brw    <= 1'b0;
                        count  <= '0;
                        out    <= '0;
                        borrow <= 1'b0;
                    end
                end
                S_SUB: begin
                    brw   <= brw_nxt;
                    out   <= {d, out[WIDTH-1:1]};
                    a_reg <= a_reg >> 1;
                    b_reg <= b_reg >> 1;
                    count <= count + CW'(1);
                    if (last_bit) borrow <= brw_nxt;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sub_serial.sv
// tb/tb_sub_serial.sv - randomized self-checking bench for sub_serial against an arithmetic model
module tb_sub_serial;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] out_w;
    logic         borrow;
    logic         done;
    logic         busy;
`ifdef SUB_SERIAL_OVF_EN
    logic         ovf;
`endif

    int n_pass  = 0;
    int n_total = 0;

    sub_serial #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .a      (a),
        .b      (b),
        .out    (out_w),
        .borrow (borrow),
        .done   (done),
`ifdef SUB_SERIAL_OVF_EN
        .ovf    (ovf),
`endif
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic logic [31:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        int d;
        d = int'(x) - int'(y);
        if (d < 0) d += (1 << W);
        return 32'(d);
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
        int sx, sy, d;
        sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
        sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
        d  = sx - sy;
        return (d > (1 << (W - 1)) - 1) || (d < -(1 << (W - 1)));
    endfunction

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input bit disturb, input string tag);
        int   done_at = -1;
        int   n_done  = 0;
        bit   busy_ok = 1'b1;
        logic [31:0] res_out;
        logic res_brw;
        @(negedge clk);
        a  = ta;
        b  = tb_v;
        en = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= W + 1; k++) begin
            @(negedge clk);
            if (disturb && k <= W) begin
                a  = W'($urandom);
                b  = W'($urandom);
                en = 1'($urandom);
            end else begin
                en = 1'b0;
            end
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                n_done++;
                done_at = k;
            end
        end
        res_out = 32'(out_w);
        res_brw = borrow;
        check({tag, " done_pos"}, 32'(done_at), 32'(W + 1));
        check({tag, " done_cnt"}, 32'(n_done), 32'd1);
        check({tag, " busy"}, 32'(busy_ok), 32'd1);
        check({tag, " out"}, res_out, ref_diff(ta, tb_v));
        check({tag, " borrow"}, 32'(res_brw), 32'(ta < tb_v));
`ifdef SUB_SERIAL_OVF_EN
        check({tag, " ovf"}, 32'(ovf), 32'(ref_ovf(ta, tb_v)));
`endif
        @(negedge clk);
        check({tag, " idle"}, {30'd0, busy, done}, 32'd0);
        check({tag, " hold"}, {23'd0, borrow, out_w}, {23'd0, res_brw, res_out[W-1:0]});
    endtask

    initial begin
        int first_done;
        int second_done;
        int seen;
        rst = 1'b1;
        en  = 1'b0;
        a   = '0;
        b   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", {22'd0, out_w, borrow, done, busy}, 32'd0);
`ifdef SUB_SERIAL_OVF_EN
        check("reset ovf", 32'(ovf), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("idle no en", {30'd0, busy, done}, 32'd0);

        run_op(8'd200, 8'd55, 1'b0, "200-55");
        run_op(8'd5, 8'd7, 1'b0, "5-7");
        run_op(8'd0, 8'd0, 1'b0, "0-0");
        run_op(8'h80, 8'h01, 1'b0, "80-01");
        run_op(8'h10, 8'h20, 1'b0, "10-20");
        run_op(8'h7F, 8'hFF, 1'b0, "7F-FF");
        run_op(8'd77, 8'd33, 1'b1, "disturb");

        // Back-to-back with en held high.
        @(negedge clk);
        a = 8'd9; b = 8'd3; en = 1'b1;
        first_done = -1; second_done = -1; seen = 0;
        for (int c = 0; c < 40 && seen < 2; c++) begin
            @(negedge clk);
            if (done) begin
                if (seen == 0) begin
                    first_done = c;
                    check("b2b first out", {23'd0, borrow, out_w}, {23'd0, 1'b0, 8'd6});
                    a = 8'd3; b = 8'd9;
                end else begin
                    second_done = c;
                    check("b2b second out", {23'd0, borrow, out_w}, {23'd0, 1'b1, 8'd250});
                    en = 1'b0;
                end
                seen++;
            end
        end
        en = 1'b0;
        check("b2b done count", 32'(seen), 32'd2);
        check("b2b spacing", 32'(second_done - first_done), 32'(W + 2));
        repeat (3) @(negedge clk);

        // Reset in the 4th SUB cycle discards the partial result.
        a = 8'd200; b = 8'd55; en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid reset", {22'd0, out_w, borrow, done, busy}, 32'd0);
        @(negedge clk);
        check("mid reset idle", 32'(busy), 32'd0);
        run_op(8'd100, 8'd1, 1'b0, "100-1");

        for (int i = 0; i < 30; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), "rand");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
